// File: rtl/ras_speculative_stack.sv
// Speculative return address stack with a committed shadow state.
// Predicted branches are logged so retirement can advance the commit copy and a flush can restore it.
module ras_speculative_stack #(
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned MAX_INFLIGHT = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        branch_fetched,
   input  logic        push,
   input  logic        pop,
   input  logic [31:0] new_addr,
   input  logic        branch_retired,
   input  logic        flush,
   output logic [31:0] addr,
   output logic        valid,
   output logic        track_full
);

   localparam int unsigned AW = 32;
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned FW = $clog2(MAX_INFLIGHT);
   localparam int unsigned OW = $clog2(MAX_INFLIGHT + 1);

   typedef struct packed {
      logic [PW-1:0] ptr;
      logic [CW-1:0] count;
   } ras_state_t;

   typedef struct packed {
      logic push;
      logic pop;
   } track_rec_t;

   logic [AW-1:0] stack [DEPTH];
   track_rec_t    track_mem [MAX_INFLIGHT];

   ras_state_t    spec_q, spec_d;
   ras_state_t    commit_q, commit_d;
   logic [FW-1:0] rd_ptr, wr_ptr;
   logic [OW-1:0] occ;

   logic          do_retire;
   logic          do_fetch;
   logic          do_write;
   logic [PW-1:0] wr_idx;
   logic [PW-1:0] top_idx;
   track_rec_t    head_rec;

   // Pop first (silent on empty), then push; a push on a full stack overwrites the oldest slot.
   function automatic ras_state_t apply_op(input ras_state_t s, input logic do_push, input logic do_pop);
      ras_state_t r;
      r = s;
      if (do_pop && (r.count != '0)) begin
         r.ptr   = r.ptr - PW'(1);
         r.count = r.count - CW'(1);
      end
      if (do_push) begin
         r.ptr = r.ptr + PW'(1);
         if (r.count != CW'(DEPTH))
            r.count = r.count + CW'(1);
      end
      return r;
   endfunction

   always_comb begin
      head_rec  = track_mem[rd_ptr];
      do_retire = branch_retired && (occ != '0);
      // A fetch that cannot be logged is dropped rather than letting the FIFO overflow.
      do_fetch  = branch_fetched && !flush && (!track_full || do_retire);
      commit_d  = commit_q;
      spec_d    = spec_q;
      if (do_retire)
         commit_d = apply_op(commit_q, head_rec.push, head_rec.pop);
      if (flush)
         spec_d = commit_d;
      else if (do_fetch)
         spec_d = apply_op(spec_q, push, pop);
      do_write = do_fetch && push;
      // After the push phase the written slot is always one below the new pointer.
      wr_idx   = spec_d.ptr - PW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         spec_q   <= '0;
         commit_q <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         occ      <= '0;
      end else begin
         spec_q   <= spec_d;
         commit_q <= commit_d;
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
         end else begin
            if (do_retire)
               rd_ptr <= rd_ptr + FW'(1);
            if (do_fetch)
               wr_ptr <= wr_ptr + FW'(1);
            if (do_fetch && !do_retire)
               occ <= occ + OW'(1);
            else if (!do_fetch && do_retire)
               occ <= occ - OW'(1);
         end
      end
   end

   // Storage arrays carry no reset; only the pointers define what is live.
   always_ff @(posedge clk) begin
      if (do_write)
         stack[wr_idx] <= new_addr;
      if (do_fetch)
         track_mem[wr_ptr] <= {push, pop};
   end

   always_comb begin
      top_idx    = spec_q.ptr - PW'(1);
      valid      = (spec_q.count != '0);
      addr       = valid ? stack[top_idx] : '0;
      track_full = (occ == OW'(MAX_INFLIGHT));
   end

endmodule

// File: tb/tb_ras_speculative_stack.sv
// Self-checking bench for ras_speculative_stack: directed scenarios plus a randomized run
// compared against a queue/array reference model of the stack and retire log.
module tb_ras_speculative_stack;

   localparam int unsigned DEPTH        = 4;
   localparam int unsigned MAX_INFLIGHT = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        branch_fetched = 1'b0;
   logic        push = 1'b0;
   logic        pop = 1'b0;
   logic [31:0] new_addr = '0;
   logic        branch_retired = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] addr;
   logic        valid;
   logic        track_full;

   int tests = 0;
   int fails = 0;

   // Reference model: physical slots, integer pointers/counts, and a queue of {push,pop} records.
   logic [31:0] m_mem [DEPTH];
   int          m_sp, m_sc, m_cp, m_cc;
   bit [1:0]    m_q [$];

   ras_speculative_stack #(.DEPTH(DEPTH), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
      .clk(clk), .rst(rst), .branch_fetched(branch_fetched), .push(push), .pop(pop),
      .new_addr(new_addr), .branch_retired(branch_retired), .flush(flush),
      .addr(addr), .valid(valid), .track_full(track_full)
   );

   always #5 clk = ~clk;

   // Fetch must stall on track_full unless a retire frees a slot in the same cycle.
   always @(posedge clk) begin
      if (!rst && branch_fetched && track_full && !branch_retired && !flush) begin
         fails++;
         $display("FAIL protocol: fetch while track_full=%0b without retire", track_full);
      end
   end

   task automatic model_op(inout int p, inout int c, input bit ps, input bit pp);
      if (pp && c > 0) begin
         p = (p + DEPTH - 1) % DEPTH;
         c--;
      end
      if (ps) begin
         p = (p + 1) % DEPTH;
         if (c < DEPTH) c++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_sp = 0; m_sc = 0; m_cp = 0; m_cc = 0;
      m_q.delete();
   endtask

   // One clock with the given inputs; model advanced with the same inputs.
   task automatic step(input logic bf, input logic ps, input logic pp, input logic [31:0] na,
                       input logic br, input logic fl);
      bit       full0;
      bit       ret;
      bit       fet;
      bit [1:0] rec;
      branch_fetched = bf; push = ps; pop = pp; new_addr = na;
      branch_retired = br; flush = fl;
      full0 = (m_q.size() == MAX_INFLIGHT);
      ret   = br && (m_q.size() != 0);
      fet   = bf && !fl && (!full0 || ret);
      if (ret) begin
         rec = m_q.pop_front();
         model_op(m_cp, m_cc, rec[1], rec[0]);
      end
      if (fl) begin
         m_sp = m_cp;
         m_sc = m_cc;
         m_q.delete();
      end else if (fet) begin
         if (pp && m_sc > 0) begin
            m_sp = (m_sp + DEPTH - 1) % DEPTH;
            m_sc--;
         end
         if (ps) begin
            m_mem[m_sp] = na;
            m_sp = (m_sp + 1) % DEPTH;
            if (m_sc < DEPTH) m_sc++;
         end
         m_q.push_back({ps, pp});
      end
      @(posedge clk);
      #1;
      branch_fetched = 1'b0; push = 1'b0; pop = 1'b0; new_addr = '0;
      branch_retired = 1'b0; flush = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid); end
      tests++; if (addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", addr); end
      tests++; if (track_full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b want 0", track_full); end
   endtask

   task automatic test_push_pop();
      do_reset();
      step(1, 1, 0, 32'h100, 0, 0);
      step(1, 1, 0, 32'h200, 0, 0);
      step(1, 1, 0, 32'h300, 0, 0);
      tests++; if (addr !== 32'h300 || valid !== 1'b1) begin fails++; $display("FAIL pp_top: addr=%h valid=%b want 300/1", addr, valid); end
      step(1, 0, 1, 32'h0, 0, 0);
      tests++; if (addr !== 32'h200) begin fails++; $display("FAIL pp_pop1: addr=%h want 200", addr); end
      step(1, 0, 1, 32'h0, 0, 0);
      step(1, 0, 1, 32'h0, 0, 0);
      tests++; if (addr !== 32'h0 || valid !== 1'b0) begin fails++; $display("FAIL pp_empty: addr=%h valid=%b want 0/0", addr, valid); end
      step(1, 0, 1, 32'h0, 0, 0);
      tests++; if (addr !== 32'h0 || valid !== 1'b0) begin fails++; $display("FAIL pp_underflow: addr=%h valid=%b want 0/0", addr, valid); end
   endtask

   task automatic test_overflow();
      logic [31:0] want [4];
      want[0] = 32'h50; want[1] = 32'h40; want[2] = 32'h30; want[3] = 32'h20;
      do_reset();
      for (int i = 1; i <= 5; i++) step(1, 1, 0, 32'(i * 16), 0, 0);
      // Pops retire older records so the log never fills.
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (addr !== want[i] || valid !== 1'b1) begin
            fails++; $display("FAIL ovf_top%0d: addr=%h valid=%b want %h/1", i, addr, valid, want[i]);
         end
         step(1, 0, 1, 32'h0, 1, 0);
      end
      tests++; if (valid !== 1'b0 || addr !== 32'h0) begin fails++; $display("FAIL ovf_drained: addr=%h valid=%b want 0/0", addr, valid); end
   endtask

   task automatic test_flush_restore();
      do_reset();
      step(1, 1, 0, 32'hA0, 0, 0);
      step(0, 0, 0, 32'h0, 1, 0);
      step(1, 1, 0, 32'hB0, 0, 0);
      step(1, 1, 0, 32'hC0, 0, 0);
      tests++; if (addr !== 32'hC0) begin fails++; $display("FAIL fr_spec: addr=%h want c0", addr); end
      step(0, 0, 0, 32'h0, 0, 1);
      tests++; if (addr !== 32'hA0 || valid !== 1'b1 || track_full !== 1'b0) begin
         fails++; $display("FAIL fr_restore: addr=%h valid=%b full=%b want a0/1/0", addr, valid, track_full);
      end
   endtask

   task automatic test_flush_after_pop();
      do_reset();
      step(1, 1, 0, 32'hA0, 0, 0);
      step(0, 0, 0, 32'h0, 1, 0);
      step(1, 0, 1, 32'h0, 0, 0);
      step(0, 0, 0, 32'h0, 1, 0);
      step(1, 1, 0, 32'hD0, 0, 0);
      step(0, 0, 0, 32'h0, 0, 1);
      tests++; if (valid !== 1'b0 || addr !== 32'h0) begin fails++; $display("FAIL fap_flush: addr=%h valid=%b want 0/0", addr, valid); end
      step(1, 1, 0, 32'hE0, 0, 0);
      tests++; if (addr !== 32'hE0 || valid !== 1'b1) begin fails++; $display("FAIL fap_push: addr=%h valid=%b want e0/1", addr, valid); end
   endtask

   task automatic test_track_full();
      do_reset();
      for (int i = 0; i < 7; i++) step(1, 0, 0, 32'h0, 0, 0);
      tests++; if (track_full !== 1'b0) begin fails++; $display("FAIL tf_seven: full=%b want 0", track_full); end
      step(1, 0, 0, 32'h0, 0, 0);
      tests++; if (track_full !== 1'b1) begin fails++; $display("FAIL tf_eight: full=%b want 1", track_full); end
      step(1, 0, 0, 32'h0, 1, 0);
      tests++; if (track_full !== 1'b1) begin fails++; $display("FAIL tf_fetch_retire: full=%b want 1", track_full); end
      step(0, 0, 0, 32'h0, 1, 0);
      tests++; if (track_full !== 1'b0) begin fails++; $display("FAIL tf_retire: full=%b want 0", track_full); end
   endtask

   task automatic test_push_pop_same();
      do_reset();
      step(1, 1, 0, 32'h40, 0, 0);
      step(1, 1, 1, 32'h44, 0, 0);
      tests++; if (addr !== 32'h44 || valid !== 1'b1) begin fails++; $display("FAIL ppsame_top: addr=%h valid=%b want 44/1", addr, valid); end
      step(1, 0, 1, 32'h0, 0, 0);
      tests++; if (valid !== 1'b0) begin fails++; $display("FAIL ppsame_count: valid=%b want 0 after one pop", valid); end
      do_reset();
      step(1, 1, 0, 32'h40, 0, 0);
      step(1, 1, 1, 32'h44, 0, 0);
      step(0, 0, 0, 32'h0, 1, 1);
      // Count is restored to 1, but the in-place replace already overwrote the committed slot.
      tests++; if (addr !== 32'h44 || valid !== 1'b1) begin fails++; $display("FAIL ppsame_flush: addr=%h valid=%b want 44/1", addr, valid); end
   endtask

   task automatic test_random();
      logic        exp_valid;
      logic [31:0] exp_addr;
      logic        exp_full;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         logic        bf, ps, pp, br, fl;
         logic [31:0] na;
         bf = ($urandom_range(0, 3) != 0);
         ps = 1'($urandom_range(0, 1));
         pp = 1'($urandom_range(0, 1));
         br = ($urandom_range(0, 2) == 0);
         fl = ($urandom_range(0, 19) == 0);
         na = $urandom;
         if (m_q.size() == MAX_INFLIGHT && !br && !fl) bf = 1'b0;
         step(bf, ps, pp, na, br, fl);
         exp_valid = (m_sc != 0);
         exp_addr  = exp_valid ? m_mem[(m_sp + DEPTH - 1) % DEPTH] : 32'h0;
         exp_full  = (m_q.size() == MAX_INFLIGHT);
         tests++; if (valid !== exp_valid) begin fails++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, valid, exp_valid); end
         tests++; if (addr !== exp_addr) begin fails++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, addr, exp_addr); end
         tests++; if (track_full !== exp_full) begin fails++; $display("FAIL rnd_full[%0d]: got %b want %b", i, track_full, exp_full); end
      end
   endtask

   initial begin
      test_reset();
      test_push_pop();
      test_overflow();
      test_flush_restore();
      test_flush_after_pop();
      test_track_full();
      test_push_pop_same();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
